// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared types and constants for the fetch PC unit
package fetch_pc_unit_pkg;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Bubble instruction placed in IF/ID (addi x0,x0,0)
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Sequential fetch stride in bytes
  localparam int unsigned PC_INC = 4;

  // Width of the squash down-counter
  localparam int unsigned FLUSH_CTR_W = 8;

endpackage

// File: rtl/fetch_flush_ctr.sv
// rtl/fetch_flush_ctr.sv - loadable down-counter timing the post-redirect squash window
module fetch_flush_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register, cleared on reset so no stale flush survives it
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC sequencer with IF/ID register, redirect squash and error flags
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  input  logic [31:0]     Inst_in,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] IF_PC,
  output logic [31:0]     IF_Inst,
  output logic            IF_Valid,
  output logic            Flush,
  output logic            Misalign_Err,
  output logic            Range_Err,
  output logic [15:0]     Redirect_Cnt
);

  localparam logic [PC_W-1:0]        RST_PC    = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]        PC_STEP   = PC_W'(PC_INC);
  localparam logic [FLUSH_CTR_W-1:0] FLUSH_LD  = FLUSH_CTR_W'(FLUSH_CYC - 1);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic            if_valid_q, if_valid_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic            range_q, range_d;
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;

  logic                   ctr_load;
  logic                   ctr_dec;
  logic                   ctr_zero;
  logic [FLUSH_CTR_W-1:0] ctr_count;

  logic [PC_W-1:0] br_target;
  logic            br_misalign;
  logic            br_range;

  // Redirect target is word-aligned and truncated to the fetch address width
  always_comb begin
    br_target   = {BrPC[PC_W-1:2], 2'b00};
    br_misalign = (BrPC[1:0] != 2'b00);
    br_range    = ((BrPC >> PC_W) != 32'd0);
  end

  // Next-state and next-register logic: redirect beats stall beats sequential fetch
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_pc_d        = if_pc_q;
    if_inst_d      = if_inst_q;
    if_valid_d     = if_valid_q;
    misalign_d     = misalign_q;
    range_d        = range_q;
    redirect_cnt_d = redirect_cnt_q;
    ctr_load       = 1'b0;
    ctr_dec        = 1'b0;

    case (state_q)
      BOOT: begin
        // One settling cycle; PC stays at the reset address
        state_d    = RUN;
        if_valid_d = 1'b0;
      end
      RUN, FLUSH: begin
        if (PcSel) begin
          state_d    = FLUSH;
          pc_d       = br_target;
          if_valid_d = 1'b0;
          ctr_load   = 1'b1;
          misalign_d = misalign_q | br_misalign;
          range_d    = range_q | br_range;
          if (redirect_cnt_q != 16'hFFFF) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
          end
        end else if (!Stall) begin
          if ((state_q == RUN) || ctr_zero) begin
            // Squash window over (or never open): fetch at PC, which holds the target after a redirect
            state_d    = RUN;
            if_pc_d    = pc_q;
            if_inst_d  = Inst_in;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_STEP;
          end else begin
            ctr_dec = 1'b1;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    flush_d = (state_d == FLUSH);
  end

  // Pipeline state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= BOOT;
      pc_q           <= RST_PC;
      if_pc_q        <= '0;
      if_inst_q      <= NOP_INST;
      if_valid_q     <= 1'b0;
      flush_q        <= 1'b0;
      misalign_q     <= 1'b0;
      range_q        <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_pc_q        <= if_pc_d;
      if_inst_q      <= if_inst_d;
      if_valid_q     <= if_valid_d;
      flush_q        <= flush_d;
      misalign_q     <= misalign_d;
      range_q        <= range_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  fetch_flush_ctr #(
    .W (FLUSH_CTR_W)
  ) u_flush_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (FLUSH_LD),
    .dec      (ctr_dec),
    .count    (ctr_count),
    .is_zero  (ctr_zero)
  );

  logic unused_ctr;
  assign unused_ctr = ^ctr_count;

  assign PC           = pc_q;
  assign IF_PC        = if_pc_q;
  assign IF_Inst      = if_inst_q;
  assign IF_Valid     = if_valid_q;
  assign Flush        = flush_q;
  assign Misalign_Err = misalign_q;
  assign Range_Err    = range_q;
  assign Redirect_Cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PcSel;
  logic [31:0] BrPC;
  logic        Stall;
  logic [31:0] Inst_in;
  logic [8:0]  PC;
  logic [8:0]  IF_PC;
  logic [31:0] IF_Inst;
  logic        IF_Valid;
  logic        Flush;
  logic        Misalign_Err;
  logic        Range_Err;
  logic [15:0] Redirect_Cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory: word encodes its own address
  assign Inst_in = 32'hA000_0000 | {23'd0, PC};

  fetch_pc_unit #(
    .PC_W      (9),
    .RESET_PC  (0),
    .FLUSH_CYC (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .Stall        (Stall),
    .Inst_in      (Inst_in),
    .PC           (PC),
    .IF_PC        (IF_PC),
    .IF_Inst      (IF_Inst),
    .IF_Valid     (IF_Valid),
    .Flush        (Flush),
    .Misalign_Err (Misalign_Err),
    .Range_Err    (Range_Err),
    .Redirect_Cnt (Redirect_Cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input string tag, input logic [8:0] pc, input logic [8:0] if_pc,
                      input logic if_valid, input logic flush);
    chk({tag, ".pc"},       32'(PC),       32'(pc));
    chk({tag, ".if_pc"},    32'(IF_PC),    32'(if_pc));
    chk({tag, ".if_valid"}, 32'(IF_Valid), 32'(if_valid));
    chk({tag, ".flush"},    32'(Flush),    32'(flush));
  endtask

  task automatic reset_vals(input string tag);
    core(tag, 9'h000, 9'h000, 1'b0, 1'b0);
    chk({tag, ".inst"},     IF_Inst,             32'h0000_0013);
    chk({tag, ".misalign"}, 32'(Misalign_Err),   32'd0);
    chk({tag, ".range"},    32'(Range_Err),      32'd0);
    chk({tag, ".cnt"},      32'(Redirect_Cnt),   32'd0);
  endtask

  initial begin
    reset = 1'b0; PcSel = 1'b0; BrPC = 32'd0; Stall = 1'b0;
    step(); step();
    reset_vals("rst");

    // Free run from reset release: BOOT cycle, then sequential fetch
    reset = 1'b1;
    step(); core("boot", 9'h000, 9'h000, 1'b0, 1'b0);
    step(); core("run0", 9'h004, 9'h000, 1'b1, 1'b0);
    chk("run0.inst", IF_Inst, 32'hA000_0000);
    step(); core("run1", 9'h008, 9'h004, 1'b1, 1'b0);
    chk("run1.inst", IF_Inst, 32'hA000_0004);
    step(); core("run2", 9'h00C, 9'h008, 1'b1, 1'b0);
    step(); core("run3", 9'h010, 9'h00C, 1'b1, 1'b0);

    // Redirect to 0x40 from PC=0x10
    PcSel = 1'b1; BrPC = 32'h40;
    step(); core("br40.a", 9'h040, 9'h00C, 1'b0, 1'b1);
    chk("br40.cnt", 32'(Redirect_Cnt), 32'd1);
    PcSel = 1'b0;
    step(); core("br40.b", 9'h040, 9'h00C, 1'b0, 1'b1);
    step(); core("br40.c", 9'h044, 9'h040, 1'b1, 1'b0);
    chk("br40.inst", IF_Inst, 32'hA000_0040);

    // Stall holds everything
    Stall = 1'b1;
    step(); core("stall", 9'h044, 9'h040, 1'b1, 1'b0);
    chk("stall.inst", IF_Inst, 32'hA000_0040);

    // Redirect with simultaneous stall is taken; stall in FLUSH extends it
    PcSel = 1'b1; BrPC = 32'h80;
    step(); core("brst.a", 9'h080, 9'h040, 1'b0, 1'b1);
    chk("brst.cnt", 32'(Redirect_Cnt), 32'd2);
    PcSel = 1'b0;
    step(); core("brst.b", 9'h080, 9'h040, 1'b0, 1'b1);
    Stall = 1'b0;
    step(); core("brst.c", 9'h080, 9'h040, 1'b0, 1'b1);
    step(); core("brst.d", 9'h084, 9'h080, 1'b1, 1'b0);

    // Back-to-back redirects: the later one wins and restarts the window
    PcSel = 1'b1; BrPC = 32'h40;
    step(); core("bb.a", 9'h040, 9'h080, 1'b0, 1'b1);
    BrPC = 32'h80;
    step(); core("bb.b", 9'h080, 9'h080, 1'b0, 1'b1);
    chk("bb.cnt", 32'(Redirect_Cnt), 32'd4);
    PcSel = 1'b0;
    step(); core("bb.c", 9'h080, 9'h080, 1'b0, 1'b1);
    step(); core("bb.d", 9'h084, 9'h080, 1'b1, 1'b0);
    chk("bb.inst", IF_Inst, 32'hA000_0080);

    // Wrap at the top of the address space with no error flags
    PcSel = 1'b1; BrPC = 32'h1FC;
    step(); core("wr.a", 9'h1FC, 9'h080, 1'b0, 1'b1);
    PcSel = 1'b0;
    step(); step(); core("wr.b", 9'h000, 9'h1FC, 1'b1, 1'b0);
    chk("wr.misalign", 32'(Misalign_Err), 32'd0);
    chk("wr.range",    32'(Range_Err),    32'd0);

    // Misaligned, out-of-range target sets both sticky flags
    PcSel = 1'b1; BrPC = 32'h202;
    step(); core("err.a", 9'h000, 9'h1FC, 1'b0, 1'b1);
    chk("err.misalign", 32'(Misalign_Err), 32'd1);
    chk("err.range",    32'(Range_Err),    32'd1);
    chk("err.cnt",      32'(Redirect_Cnt), 32'd6);
    PcSel = 1'b0;
    step(); step(); core("err.b", 9'h004, 9'h000, 1'b1, 1'b0);
    chk("err.misalign2", 32'(Misalign_Err), 32'd1);
    chk("err.range2",    32'(Range_Err),    32'd1);

    // Reset in the middle of a flush window discards it
    PcSel = 1'b1; BrPC = 32'h40;
    step(); core("rf.a", 9'h040, 9'h000, 1'b0, 1'b1);
    PcSel = 1'b0; reset = 1'b0;
    step(); reset_vals("rf.rst");
    reset = 1'b1;
    step(); core("rf.boot", 9'h000, 9'h000, 1'b0, 1'b0);
    step(); core("rf.run", 9'h004, 9'h000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
